// File: rtl/mainm_arbiter_pkg.sv
// Shared encodings for the two-master main-memory arbiter: FSM states,
// abort data pattern and one-hot grant values.
package mainm_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_t;

  localparam logic [31:0] ARB_ABORT_DATA = 32'hFFFF_FFFF;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  function automatic logic [1:0] grant_onehot(input logic owner);
    return owner ? GRANT_M1 : GRANT_M0;
  endfunction

endpackage

// File: rtl/mainm_arbiter_rr_pick.sv
// Combinational 2-requester picker: the only requester wins, otherwise the
// master not served last (or master 0 when fixed priority is selected).
module arb_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed_prio,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    case (req)
      2'b10:   winner = 1'b1;
      2'b11:   winner = fixed_prio ? 1'b0 : ~last;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/mainm_arbiter.sv
// Two-master arbiter for the main-memory port: one transaction per grant,
// burst-aware, with a watchdog that force-completes hung transactions.
module mainm_arbiter
  import mainm_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter bit          FIXED_PRIO     = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_a,
  input  logic [31:0] m0_d,
  input  logic        m0_we,
  input  logic        m0_rd,
  input  logic        m0_burst_en,
  input  logic [7:0]  m0_burst_length,
  input  logic [31:0] m1_a,
  input  logic [31:0] m1_d,
  input  logic        m1_we,
  input  logic        m1_rd,
  input  logic        m1_burst_en,
  input  logic [7:0]  m1_burst_length,
  output logic [31:0] m0_spo,
  output logic        m0_ready,
  output logic [31:0] m1_spo,
  output logic        m1_ready,
  output logic [31:0] mem_a,
  output logic [31:0] mem_d,
  output logic        mem_we,
  output logic        mem_rd,
  output logic        mem_burst_en,
  output logic [7:0]  mem_burst_length,
  input  logic [31:0] mem_spo,
  input  logic        mem_ready,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);

  arb_state_t  state_reg, state_next;
  logic        owner_reg, owner_next;
  logic        last_reg, last_next;
  logic [1:0]  grant_reg, grant_next;
  logic [31:0] a_reg, a_next, d_reg, d_next;
  logic        we_reg, we_next, rd_reg, rd_next;
  logic        burst_en_reg, burst_en_next;
  logic [7:0]  burst_len_reg, burst_len_next;
  logic [7:0]  beat_reg, beat_next;
  logic [31:0] wdog_reg, wdog_next;
  logic [31:0] spo0_reg, spo0_next, spo1_reg, spo1_next;

  logic        pick_winner, pick_valid;
  logic        last_beat, abort, beat_fire;
  logic [7:0]  len_eff;
  logic [31:0] beat_data;

  arb_rr_pick u_pick (
    .req        ({m1_rd | m1_we, m0_rd | m0_we}),
    .last       (last_reg),
    .fixed_prio (FIXED_PRIO),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  assign len_eff   = (burst_len_reg == 8'd0) ? 8'd1 : burst_len_reg;
  assign last_beat = !burst_en_reg || (({1'b0, beat_reg} + 9'd1) == {1'b0, len_eff});

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    last_next      = last_reg;
    grant_next     = grant_reg;
    a_next         = a_reg;
    d_next         = d_reg;
    we_next        = we_reg;
    rd_next        = rd_reg;
    burst_en_next  = burst_en_reg;
    burst_len_next = burst_len_reg;
    beat_next      = beat_reg;
    wdog_next      = wdog_reg;
    abort          = 1'b0;
    case (state_reg)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_next     = ARB_BUSY;
          owner_next     = pick_winner;
          grant_next     = grant_onehot(pick_winner);
          a_next         = pick_winner ? m1_a : m0_a;
          d_next         = pick_winner ? m1_d : m0_d;
          we_next        = pick_winner ? m1_we : m0_we;
          rd_next        = pick_winner ? m1_rd : m0_rd;
          burst_en_next  = pick_winner ? m1_burst_en : m0_burst_en;
          burst_len_next = pick_winner ? m1_burst_length : m0_burst_length;
          beat_next      = 8'd0;
          wdog_next      = 32'd0;
        end
      end
      ARB_BUSY: begin
        if (mem_ready) begin
          beat_next = beat_reg + 8'd1;
          wdog_next = 32'd0;
          if (last_beat) state_next = ARB_GAP;
        end else if ((TIMEOUT_CYCLES != 0) && (wdog_reg == WDOG_LAST)) begin
          abort      = 1'b1;
          state_next = ARB_GAP;
        end else begin
          wdog_next = wdog_reg + 32'd1;
        end
      end
      ARB_GAP: begin
        last_next  = owner_reg;
        grant_next = GRANT_NONE;
        state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // A real memory beat takes precedence over the abort pattern.
  assign beat_fire = (state_reg == ARB_BUSY) && (mem_ready || abort);
  assign beat_data = mem_ready ? mem_spo : ARB_ABORT_DATA;
  assign m0_ready  = beat_fire && !owner_reg;
  assign m1_ready  = beat_fire && owner_reg;
  assign spo0_next = m0_ready ? beat_data : spo0_reg;
  assign spo1_next = m1_ready ? beat_data : spo1_reg;
  assign m0_spo    = spo0_next;
  assign m1_spo    = spo1_next;

  assign timeout_err      = abort;
  assign grant            = grant_reg;
  assign mem_a            = a_reg;
  assign mem_d            = d_reg;
  assign mem_we           = (state_reg == ARB_BUSY) && we_reg;
  assign mem_rd           = (state_reg == ARB_BUSY) && rd_reg && !we_reg;
  assign mem_burst_en     = (state_reg == ARB_BUSY) && burst_en_reg;
  assign mem_burst_length = burst_len_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ARB_IDLE;
      owner_reg     <= 1'b0;
      last_reg      <= 1'b1;
      grant_reg     <= GRANT_NONE;
      a_reg         <= 32'd0;
      d_reg         <= 32'd0;
      we_reg        <= 1'b0;
      rd_reg        <= 1'b0;
      burst_en_reg  <= 1'b0;
      burst_len_reg <= 8'd0;
      beat_reg      <= 8'd0;
      wdog_reg      <= 32'd0;
      spo0_reg      <= 32'd0;
      spo1_reg      <= 32'd0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      last_reg      <= last_next;
      grant_reg     <= grant_next;
      a_reg         <= a_next;
      d_reg         <= d_next;
      we_reg        <= we_next;
      rd_reg        <= rd_next;
      burst_en_reg  <= burst_en_next;
      burst_len_reg <= burst_len_next;
      beat_reg      <= beat_next;
      wdog_reg      <= wdog_next;
      spo0_reg      <= spo0_next;
      spo1_reg      <= spo1_next;
    end
  end

endmodule

// File: tb/tb_mainm_arbiter.sv
// Directed bench for mainm_arbiter: round-robin and fixed-priority instances
// share one stimulus; inputs change and outputs are sampled on the falling edge.
module tb_mainm_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_a, m0_d, m1_a, m1_d, mem_spo;
  logic        m0_we, m0_rd, m0_burst_en, m1_we, m1_rd, m1_burst_en, mem_ready;
  logic [7:0]  m0_burst_length, m1_burst_length;

  logic [31:0] m0_spo, m1_spo, mem_a, mem_d;
  logic        m0_ready, m1_ready, mem_we, mem_rd, mem_burst_en, timeout_err;
  logic [7:0]  mem_burst_length;
  logic [1:0]  grant;

  logic [31:0] b_m0_spo, b_m1_spo, b_mem_a, b_mem_d;
  logic        b_m0_ready, b_m1_ready, b_mem_we, b_mem_rd, b_mem_burst_en, b_timeout_err;
  logic [7:0]  b_mem_burst_length;
  logic [1:0]  b_grant;

  int checks = 0;
  int errors = 0;
  int pulses;

  always #5 clk = ~clk;

  mainm_arbiter #(.TIMEOUT_CYCLES(16), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .m0_a(m0_a), .m0_d(m0_d), .m0_we(m0_we), .m0_rd(m0_rd),
    .m0_burst_en(m0_burst_en), .m0_burst_length(m0_burst_length),
    .m1_a(m1_a), .m1_d(m1_d), .m1_we(m1_we), .m1_rd(m1_rd),
    .m1_burst_en(m1_burst_en), .m1_burst_length(m1_burst_length),
    .m0_spo(m0_spo), .m0_ready(m0_ready), .m1_spo(m1_spo), .m1_ready(m1_ready),
    .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_rd(mem_rd),
    .mem_burst_en(mem_burst_en), .mem_burst_length(mem_burst_length),
    .mem_spo(mem_spo), .mem_ready(mem_ready), .grant(grant), .timeout_err(timeout_err)
  );

  mainm_arbiter #(.TIMEOUT_CYCLES(4096), .FIXED_PRIO(1'b1)) dut_fixed (
    .clk(clk), .rst(rst),
    .m0_a(m0_a), .m0_d(m0_d), .m0_we(m0_we), .m0_rd(m0_rd),
    .m0_burst_en(m0_burst_en), .m0_burst_length(m0_burst_length),
    .m1_a(m1_a), .m1_d(m1_d), .m1_we(m1_we), .m1_rd(m1_rd),
    .m1_burst_en(m1_burst_en), .m1_burst_length(m1_burst_length),
    .m0_spo(b_m0_spo), .m0_ready(b_m0_ready), .m1_spo(b_m1_spo), .m1_ready(b_m1_ready),
    .mem_a(b_mem_a), .mem_d(b_mem_d), .mem_we(b_mem_we), .mem_rd(b_mem_rd),
    .mem_burst_en(b_mem_burst_en), .mem_burst_length(b_mem_burst_length),
    .mem_spo(mem_spo), .mem_ready(mem_ready), .grant(b_grant), .timeout_err(b_timeout_err)
  );

  task automatic do_reset;
    rst = 1'b1;
    m0_a = '0; m0_d = '0; m0_we = 1'b0; m0_rd = 1'b0; m0_burst_en = 1'b0; m0_burst_length = '0;
    m1_a = '0; m1_d = '0; m1_we = 1'b0; m1_rd = 1'b0; m1_burst_en = 1'b0; m1_burst_length = '0;
    mem_spo = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
    checks++; if ({mem_we, mem_rd, mem_burst_en} !== 3'b000) begin errors++; $display("FAIL reset_mem_ctl: got %b expected 000", {mem_we, mem_rd, mem_burst_en}); end
    checks++; if ({mem_a, mem_d, mem_burst_length} !== 72'd0) begin errors++; $display("FAIL reset_mem_data: got %h expected 0", {mem_a, mem_d, mem_burst_length}); end
    checks++; if ({m0_ready, m1_ready, timeout_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b expected 000", {m0_ready, m1_ready, timeout_err}); end
    checks++; if ({m0_spo, m1_spo} !== 64'd0) begin errors++; $display("FAIL reset_spo: got %h expected 0", {m0_spo, m1_spo}); end
    $display("test_reset done");
  endtask

  task automatic test_single_read;
    do_reset;
    m0_rd = 1'b1; m0_a = 32'h0000_0100;
    #1;
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL read_rd_early: got %b expected 0", mem_rd); end
    @(negedge clk); #1;
    checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL read_rd_rise: got %b expected 1", mem_rd); end
    checks++; if (mem_a !== 32'h0000_0100) begin errors++; $display("FAIL read_addr: got %h expected 00000100", mem_a); end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL read_grant: got %b expected 01", grant); end
    repeat (4) @(negedge clk);
    #1;
    checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL read_no_early_ready: got %b expected 0", m0_ready); end
    @(negedge clk);
    mem_ready = 1'b1; mem_spo = 32'hDEAD_BEEF;
    #1;
    checks++; if (m0_ready !== 1'b1) begin errors++; $display("FAIL read_ready: got %b expected 1", m0_ready); end
    checks++; if (m0_spo !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_spo: got %h expected deadbeef", m0_spo); end
    checks++; if ({m1_ready, m1_spo} !== 33'd0) begin errors++; $display("FAIL read_other_idle: got %h expected 0", {m1_ready, m1_spo}); end
    @(negedge clk);
    mem_ready = 1'b0; m0_rd = 1'b0; mem_spo = 32'h1111_1111;
    #1;
    checks++; if ({mem_rd, m0_ready, grant} !== 4'b0001) begin errors++; $display("FAIL read_gap: got %b expected 0001", {mem_rd, m0_ready, grant}); end
    @(negedge clk); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL read_grant_idle: got %b expected 00", grant); end
    checks++; if (m0_spo !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_spo_hold: got %h expected deadbeef", m0_spo); end
    $display("test_single_read done");
  endtask

  task automatic test_collision;
    do_reset;
    m0_we = 1'b1; m0_d = 32'hAAAA_0000; m1_we = 1'b1; m1_d = 32'hBBBB_1111;
    @(negedge clk); #1;
    checks++; if ({grant, b_grant} !== 4'b0101) begin errors++; $display("FAIL coll1_grant: got %b expected 0101", {grant, b_grant}); end
    checks++; if (mem_d !== 32'hAAAA_0000) begin errors++; $display("FAIL coll1_data: got %h expected aaaa0000", mem_d); end
    mem_ready = 1'b1;
    #1;
    checks++; if ({m0_ready, m1_ready} !== 2'b10) begin errors++; $display("FAIL coll1_ready: got %b expected 10", {m0_ready, m1_ready}); end
    @(negedge clk);
    mem_ready = 1'b0; m0_we = 1'b0;
    @(negedge clk);
    m0_we = 1'b1;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL coll2_rr_grant: got %b expected 10", grant); end
    checks++; if (b_grant !== 2'b01) begin errors++; $display("FAIL coll2_fixed_grant: got %b expected 01", b_grant); end
    checks++; if ({mem_d, b_mem_d} !== {32'hBBBB_1111, 32'hAAAA_0000}) begin errors++; $display("FAIL coll2_data: got %h expected bbbb1111aaaa0000", {mem_d, b_mem_d}); end
    mem_ready = 1'b1;
    #1;
    checks++; if ({m0_ready, m1_ready, b_m0_ready, b_m1_ready} !== 4'b0110) begin errors++; $display("FAIL coll2_ready: got %b expected 0110", {m0_ready, m1_ready, b_m0_ready, b_m1_ready}); end
    @(negedge clk);
    mem_ready = 1'b0; m1_we = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL coll3_grant: got %b expected 01", grant); end
    mem_ready = 1'b1;
    #1;
    checks++; if (m0_ready !== 1'b1) begin errors++; $display("FAIL coll3_ready: got %b expected 1", m0_ready); end
    @(negedge clk);
    mem_ready = 1'b0; m0_we = 1'b0;
    $display("test_collision done");
  endtask

  task automatic test_burst;
    do_reset;
    m1_rd = 1'b1; m1_a = 32'h0000_0400; m1_burst_en = 1'b1; m1_burst_length = 8'd4;
    @(negedge clk); #1;
    checks++; if ({grant, mem_rd, mem_burst_en, mem_burst_length} !== {2'b10, 2'b11, 8'd4}) begin errors++; $display("FAIL burst_start: got %h expected %h", {grant, mem_rd, mem_burst_en, mem_burst_length}, {2'b10, 2'b11, 8'd4}); end
    pulses = 0;
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mem_spo = 32'h0000_1000 + i;
      #1;
      if (m1_ready) pulses++;
      if (m0_ready) pulses += 100;
      if (i == 4) begin
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL burst_gap: got %b expected 0", mem_rd); end
        m1_rd = 1'b0;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    checks++; if (pulses !== 4) begin errors++; $display("FAIL burst_pulses: got %0d expected 4", pulses); end
    #1;
    checks++; if (m1_spo !== 32'h0000_1003) begin errors++; $display("FAIL burst_last_spo: got %h expected 00001003", m1_spo); end
    m1_rd = 1'b1; m1_burst_length = 8'd0;
    @(negedge clk);
    pulses = 0;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (m1_ready) pulses++;
      if (i == 0) m1_rd = 1'b0;
      if (i == 1) begin
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL burst0_gap: got %b expected 0", mem_rd); end
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    checks++; if (pulses !== 1) begin errors++; $display("FAIL burst0_pulses: got %0d expected 1", pulses); end
    $display("test_burst done");
  endtask

  task automatic test_timeout;
    do_reset;
    m0_rd = 1'b1; m0_a = 32'h0000_0800;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk); #1;
      if (k == 2) begin m1_rd = 1'b1; m1_a = 32'h0000_0900; end
      if (k == 15) begin
        checks++; if ({timeout_err, m0_ready} !== 2'b00) begin errors++; $display("FAIL tmo_early: got %b expected 00", {timeout_err, m0_ready}); end
      end
      if (k == 16) begin
        checks++; if ({timeout_err, m0_ready, m1_ready} !== 3'b110) begin errors++; $display("FAIL tmo_pulse: got %b expected 110", {timeout_err, m0_ready, m1_ready}); end
        checks++; if (m0_spo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL tmo_spo: got %h expected ffffffff", m0_spo); end
        m0_rd = 1'b0;
      end
    end
    @(negedge clk); #1;
    checks++; if ({timeout_err, mem_rd, m0_ready} !== 3'b000) begin errors++; $display("FAIL tmo_gap: got %b expected 000", {timeout_err, mem_rd, m0_ready}); end
    checks++; if (m0_spo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL tmo_spo_hold: got %h expected ffffffff", m0_spo); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({grant, mem_a} !== {2'b10, 32'h0000_0900}) begin errors++; $display("FAIL tmo_next_grant: got %h expected 200000900", {grant, mem_a}); end
    mem_ready = 1'b1; mem_spo = 32'h5A5A_5A5A;
    #1;
    checks++; if ({m1_ready, m1_spo} !== {1'b1, 32'h5A5A_5A5A}) begin errors++; $display("FAIL tmo_next_ready: got %h expected 15a5a5a5a", {m1_ready, m1_spo}); end
    @(negedge clk);
    mem_ready = 1'b0; m1_rd = 1'b0;
    $display("test_timeout done");
  endtask

  task automatic test_rd_we;
    do_reset;
    m0_rd = 1'b1; m0_we = 1'b1; m0_d = 32'h1234_5678; m0_a = 32'h0000_0040;
    @(negedge clk); #1;
    checks++; if ({mem_we, mem_rd} !== 2'b10) begin errors++; $display("FAIL rdwe_ctl: got %b expected 10", {mem_we, mem_rd}); end
    checks++; if (mem_d !== 32'h1234_5678) begin errors++; $display("FAIL rdwe_data: got %h expected 12345678", mem_d); end
    m0_d = 32'h0; m0_a = 32'h0000_FFFF;
    @(negedge clk); #1;
    checks++; if ({mem_a, mem_d} !== {32'h0000_0040, 32'h1234_5678}) begin errors++; $display("FAIL rdwe_latched: got %h expected 0000004012345678", {mem_a, mem_d}); end
    mem_ready = 1'b1;
    #1;
    checks++; if (m0_ready !== 1'b1) begin errors++; $display("FAIL rdwe_ready: got %b expected 1", m0_ready); end
    @(negedge clk);
    mem_ready = 1'b0; m0_rd = 1'b0; m0_we = 1'b0;
    $display("test_rd_we done");
  endtask

  task automatic test_mid_reset;
    do_reset;
    m0_rd = 1'b1; m0_a = 32'h0000_0123;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL mrst_grant_busy: got %b expected 01", grant); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_ready = 1'b1; mem_spo = 32'h7777_7777;
    #1;
    checks++; if ({grant, mem_rd, mem_we} !== 4'b0000) begin errors++; $display("FAIL mrst_idle: got %b expected 0000", {grant, mem_rd, mem_we}); end
    checks++; if ({m0_ready, m1_ready, m0_spo} !== 34'd0) begin errors++; $display("FAIL mrst_no_ready: got %h expected 0", {m0_ready, m1_ready, m0_spo}); end
    rst = 1'b0; mem_ready = 1'b0; m0_rd = 1'b0; m1_rd = 1'b1; m1_a = 32'h0000_0200;
    @(negedge clk); #1;
    checks++; if ({grant, mem_rd, mem_a} !== {2'b10, 1'b1, 32'h0000_0200}) begin errors++; $display("FAIL mrst_new_grant: got %h expected %h", {grant, mem_rd, mem_a}, {2'b10, 1'b1, 32'h0000_0200}); end
    mem_ready = 1'b1; mem_spo = 32'hCAFE_F00D;
    #1;
    checks++; if ({m1_ready, m1_spo} !== {1'b1, 32'hCAFE_F00D}) begin errors++; $display("FAIL mrst_new_ready: got %h expected 1cafef00d", {m1_ready, m1_spo}); end
    @(negedge clk);
    mem_ready = 1'b0; m1_rd = 1'b0;
    $display("test_mid_reset done");
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_collision;
    test_burst;
    test_timeout;
    test_rd_we;
    test_mid_reset;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mainm_arbiter.md
Name: mainm_arbiter

Overview:
- Two-master arbiter sharing the main-memory port (memory controller / PSRAM path) between the CPU-side master (cache or serial-boot output) and a second DMA master (video framebuffer fetch, Ethernet DMA).
- Sits between those masters and the memory controller's a/d/we/rd/spo/ready/burst interface.
- Round-robin grant, one transaction per grant, burst-aware.
- A watchdog completes hung transactions so no master deadlocks.

Parameters:
- TIMEOUT_CYCLES, 4096: cycles without mem_ready before a forced abort; 0 disables the watchdog.
- FIXED_PRIO, 0: 1 makes master 0 always win on collision; 0 selects round-robin.

Ports:
- clk  in  1  system clock (clk_main domain)
- rst  in  1  synchronous, active-high reset
- m0_a / m1_a  in  32  byte address
- m0_d / m1_d  in  32  write data
- m0_we / m1_we  in  1  write request; level, held until ready
- m0_rd / m1_rd  in  1  read request; level, held until ready
- m0_burst_en / m1_burst_en  in  1  burst transaction
- m0_burst_length / m1_burst_length  in  8  words in burst; 0 is treated as 1
- m0_spo / m1_spo  out  32  read data
- m0_ready / m1_ready  out  1  per-word completion pulse
- mem_a  out  32
- mem_d  out  32
- mem_we  out  1
- mem_rd  out  1
- mem_burst_en  out  1
- mem_burst_length  out  8
- mem_spo  in  32
- mem_ready  in  1
- grant  out  2  one-hot current owner; 00 when idle
- timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values:
  - State IDLE; grant=00; last-served pointer = master 1, so master 0 wins the first collision.
  - mem_we=mem_rd=mem_burst_en=0; mem_a=mem_d=0; mem_burst_length=0.
  - m*_ready=0; m*_spo=0; timeout_err=0.
- A request is (mX_rd | mX_we). If both are set, we wins and mem_rd is forced 0.
- IDLE:
  - On any request, register the winner: the only requester, otherwise the master not served last (or master 0 if FIXED_PRIO).
  - Latch the winner's a/d/we/rd/burst fields into registers; go to BUSY.
  - mem_rd/mem_we rise exactly 1 cycle after the request is first seen.
- BUSY:
  - mem_* driven from the latched registers.
  - On each mem_ready: assert the owner's mX_ready the same cycle and pass mem_spo through combinationally to mX_spo. The other master's ready stays 0 and its spo holds its last value.
  - Beat counter increments on each mem_ready and clears on grant.
  - The transaction ends on the beat where count+1 == max(burst_length,1), or on the first ready if burst_en=0; then go to GAP.
  - Watchdog counter clears on grant and on each mem_ready, and increments otherwise.
  - When the watchdog reaches TIMEOUT_CYCLES: pulse timeout_err, pulse the owner's ready with spo=32'hFFFF_FFFF, go to GAP.
- GAP:
  - One cycle with mem_rd=mem_we=0 so the memory controller sees deassertion.
  - Update last-served; grant=00; go to IDLE.
  - A requester must drop rd/we in the cycle after its final ready. Anything still asserted in IDLE is a new request.
- Back-to-back throughput: minimum 3 cycles per single-word transaction overhead (IDLE, BUSY, GAP) plus memory latency.
- Simultaneous events:
  - Both masters requesting in IDLE resolves per priority.
  - A request arriving in BUSY or GAP waits; request inputs are not latched.
  - mem_ready in IDLE or GAP is ignored; no master ready is generated.
- Mid-operation reset: next edge returns to IDLE with all reset values; the in-flight transaction is dropped and no ready is issued.
- Latched request fields remain stable for the whole grant even if the master changes its inputs.

Decomposition:
- Shared package (quasi.vh-style defines):
  - state encodings ARB_IDLE/ARB_BUSY/ARB_GAP;
  - ARB_ABORT_DATA=32'hFFFF_FFFF;
  - grant encodings.
- One natural sub-module: arb_rr_pick, combinational, 2-requester round-robin picker (req[1:0], last, fixed_prio -> winner) reused for future N-way expansion.
- Watchdog and beat counter stay inline.

Test Plan:
- m0 read a=0x0000_0100 only; memory returns 0xDEADBEEF after 5 cycles -> mem_rd rises 1 cycle after request, m0_ready one pulse with m0_spo=0xDEADBEEF, grant=01 then 00 after GAP.
- m0 and m1 both write in the same cycle, twice -> first grant m0, then m1, then m0 (round-robin); with FIXED_PRIO=1 m0 wins both collisions.
- m1 burst read, burst_length=4, memory gives 4 ready pulses -> exactly 4 m1_ready pulses and a single GAP after the 4th; burst_length=0 ends after 1 beat.
- TIMEOUT_CYCLES=16, memory never readies -> timeout_err pulses on cycle 16 of BUSY, m0_ready pulses with spo=0xFFFFFFFF, arbiter then serves pending m1.
- m0 asserts rd and we together with d=0x12345678 -> mem_we=1, mem_rd=0, mem_d=0x12345678.
- rst asserted mid-BUSY -> next edge grant=00, mem_rd=mem_we=0, no m*_ready; after release, a new m1 request is granted normally.
